// File: rtl/frame_scheduler_if.sv
// frame_scheduler_if: host write, commit and LED-driver read signals of frame_scheduler
// Ports (master = host/driver side, slave = scheduler side):
//   wr_en, wr_addr, wr_data   master->slave  host channel write, one per cycle
//   wr_ready, wr_err          slave->master  write accepted / dropped-write pulse
//   commit                    master->slave  request back->front swap
//   commit_busy               slave->master  commit accepted and not yet copied
//   frame_start, blank        master->slave  driver frame boundary / force read data to 0
//   rd_addr                   master->slave  driver read address
//   rd_data                   slave->master  front-bank data, 1-cycle latency
//   front_bank, frame_count   slave->master  displayed bank index, frames since reset
interface frame_scheduler_if #(
    parameter int c_addr_w = 10,
    parameter int c_bpc    = 12,
    parameter int c_fcnt_w = 16
);
    logic                wr_en;
    logic [c_addr_w-1:0] wr_addr;
    logic [c_bpc-1:0]    wr_data;
    logic                wr_ready;
    logic                wr_err;
    logic                commit;
    logic                commit_busy;
    logic                frame_start;
    logic                blank;
    logic [c_addr_w-1:0] rd_addr;
    logic [c_bpc-1:0]    rd_data;
    logic                front_bank;
    logic [c_fcnt_w-1:0] frame_count;
    modport master (
        output wr_en, wr_addr, wr_data, commit, frame_start, blank, rd_addr,
        input  wr_ready, wr_err, commit_busy, rd_data, front_bank, frame_count
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, commit, frame_start, blank, rd_addr,
        output wr_ready, wr_err, commit_busy, rd_data, front_bank, frame_count
    );
endinterface

// File: rtl/frame_scheduler.sv
// frame_scheduler: double-buffered pixel store with frame-aligned bank swap and front->back copy
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous reset, active-low
//   bus    frame_scheduler_if.slave: host writes into the back bank, commit requests a swap,
//          driver reads the front bank by channel address with 1-cycle latency
module frame_scheduler #(
    parameter int c_ledboards = 30,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_bpc       = 12,
    parameter int c_fcnt_w    = 16
) (
    input logic              clk,
    input logic              rst_n,
    frame_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COPY} state_t;
    // one bit wider than an address so c_channels itself is representable
    localparam logic [c_addr_w:0] c_lim = (c_addr_w + 1)'(c_channels);
    state_t              state, state_nx;
    logic [c_bpc-1:0]    mem [2][c_channels];
    logic                front;
    logic [c_addr_w:0]   cnt;
    logic [c_addr_w-1:0] cp_waddr;
    logic [c_bpc-1:0]    cp_data;
    logic                wr_ok, rd_ok, swap, last, cp_rd, cp_wr;
    assign bus.wr_ready    = state == S_IDLE;
    assign bus.commit_busy = state != S_IDLE;
    assign bus.front_bank  = front;
    assign wr_ok    = bus.wr_en && bus.wr_ready && ({1'b0, bus.wr_addr} < c_lim);
    assign rd_ok    = !bus.blank && ({1'b0, bus.rd_addr} < c_lim);
    assign swap     = state == S_PENDING && bus.frame_start;
    assign last     = cnt == c_lim;
    // copy is a 2-stage pipe: read new front[cnt], write new back[cnt-1]
    assign cp_rd    = state == S_COPY && !last;
    assign cp_wr    = state == S_COPY && cnt != '0;
    assign cp_waddr = c_addr_w'(cnt - 1'b1);
    always_comb begin
        state_nx = state;
        if (state == S_IDLE && bus.commit) state_nx = S_PENDING;
        if (swap) state_nx = S_COPY;
        if (state == S_COPY && last) state_nx = S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            front           <= 1'b0;
            cnt             <= '0;
            bus.wr_err      <= 1'b0;
            bus.rd_data     <= '0;
            bus.frame_count <= '0;
        end else begin
            state           <= state_nx;
            front           <= front ^ swap;
            cnt             <= swap ? '0 : (state == S_COPY ? cnt + 1'b1 : cnt);
            bus.wr_err      <= bus.wr_en && !wr_ok;
            bus.rd_data     <= rd_ok ? mem[front][bus.rd_addr] : '0;
            bus.frame_count <= bus.frame_start ? bus.frame_count + 1'b1 : bus.frame_count;
        end
    end
    // bank RAM is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (cp_rd) cp_data <= mem[front][cnt[c_addr_w-1:0]];
        if (wr_ok) mem[~front][bus.wr_addr] <= bus.wr_data;
        else if (cp_wr) mem[~front][cp_waddr] <= cp_data;
    end
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed self-checking bench for frame_scheduler
module tb_frame_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    frame_scheduler_if #(.c_addr_w(10), .c_bpc(12), .c_fcnt_w(16)) bus ();
    frame_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic write(input logic [9:0] a, input logic [11:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask
    task automatic commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
    endtask
    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask
    task automatic read(input logic [9:0] a);
        bus.rd_addr = a;
        tick();
    endtask
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.commit_busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        write(10'd5, 12'h123);
        commit();
        frame();
        wait_idle(n);
        n_cmp++; if (n !== 961) begin n_bad++; $display("FAIL preload_copy_len got=%0d want=961", n); end
        bus.rd_addr = 10'd5;
        bus.wr_en = 1'b1; bus.wr_addr = 10'd960;
        rst_n = 1'b0;
        tick();
        tick();
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.front_bank !== 1'b0) begin n_bad++; $display("FAIL reset_front got=%0d want=0", bus.front_bank); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%0d want=1", bus.wr_ready); end
        n_cmp++; if (bus.wr_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0d want=0", bus.wr_err); end
        n_cmp++; if (bus.commit_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0d want=0", bus.commit_busy); end
        n_cmp++; if (bus.rd_data !== 12'h000) begin n_bad++; $display("FAIL reset_rd_data got=%h want=000", bus.rd_data); end
        n_cmp++; if (bus.frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_fcnt got=%0d want=0", bus.frame_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_no_swap();
        write(10'd5, 12'hABC);
        n_cmp++; if (bus.wr_err !== 1'b0) begin n_bad++; $display("FAIL noswap_err got=%0d want=0", bus.wr_err); end
        bus.rd_addr = 10'd5;
        frame();
        n_cmp++; if (bus.front_bank !== 1'b0) begin n_bad++; $display("FAIL noswap_front got=%0d want=0", bus.front_bank); end
        n_cmp++; if (bus.rd_data !== 12'h123) begin n_bad++; $display("FAIL noswap_rd got=%h want=123", bus.rd_data); end
        n_cmp++; if (bus.frame_count !== 16'd1) begin n_bad++; $display("FAIL noswap_fcnt got=%0d want=1", bus.frame_count); end
        n_cmp++; if (bus.commit_busy !== 1'b0) begin n_bad++; $display("FAIL noswap_busy got=%0d want=0", bus.commit_busy); end
    endtask

    task automatic test_swap();
        int n;
        write(10'd5, 12'hABC);
        commit();
        n_cmp++; if (bus.commit_busy !== 1'b1) begin n_bad++; $display("FAIL swap_busy got=%0d want=1", bus.commit_busy); end
        n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL swap_ready got=%0d want=0", bus.wr_ready); end
        n_cmp++; if (bus.front_bank !== 1'b0) begin n_bad++; $display("FAIL swap_front_pend got=%0d want=0", bus.front_bank); end
        bus.rd_addr = 10'd5;
        frame();
        n_cmp++; if (bus.front_bank !== 1'b1) begin n_bad++; $display("FAIL swap_front got=%0d want=1", bus.front_bank); end
        n_cmp++; if (bus.rd_data !== 12'h123) begin n_bad++; $display("FAIL swap_rd_old got=%h want=123", bus.rd_data); end
        tick();
        n_cmp++; if (bus.rd_data !== 12'hABC) begin n_bad++; $display("FAIL swap_rd_new got=%h want=abc", bus.rd_data); end
        n = 1;
        while (bus.commit_busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 961) begin n_bad++; $display("FAIL swap_busy_len got=%0d want=961", n); end
        commit();
        frame();
        wait_idle(n);
        n_cmp++; if (n !== 961) begin n_bad++; $display("FAIL swap2_busy_len got=%0d want=961", n); end
        n_cmp++; if (bus.front_bank !== 1'b0) begin n_bad++; $display("FAIL swap2_front got=%0d want=0", bus.front_bank); end
        read(10'd5);
        n_cmp++; if (bus.rd_data !== 12'hABC) begin n_bad++; $display("FAIL swap2_back_copy got=%h want=abc", bus.rd_data); end
    endtask

    task automatic test_drop();
        int n;
        write(10'd7, 12'h070);
        write(10'd8, 12'h080);
        commit();
        write(10'd7, 12'h777);
        n_cmp++; if (bus.wr_err !== 1'b1) begin n_bad++; $display("FAIL drop_pend_err got=%0d want=1", bus.wr_err); end
        tick();
        n_cmp++; if (bus.wr_err !== 1'b0) begin n_bad++; $display("FAIL drop_err_pulse got=%0d want=0", bus.wr_err); end
        commit();
        frame();
        n_cmp++; if (bus.front_bank !== 1'b1) begin n_bad++; $display("FAIL drop_front got=%0d want=1", bus.front_bank); end
        write(10'd8, 12'h888);
        n_cmp++; if (bus.wr_err !== 1'b1) begin n_bad++; $display("FAIL drop_copy_err got=%0d want=1", bus.wr_err); end
        frame();
        n_cmp++; if (bus.front_bank !== 1'b1) begin n_bad++; $display("FAIL drop_copy_frame got=%0d want=1", bus.front_bank); end
        wait_idle(n);
        n_cmp++; if (n !== 959) begin n_bad++; $display("FAIL drop_busy_len got=%0d want=959", n); end
        frame();
        n_cmp++; if (bus.front_bank !== 1'b1) begin n_bad++; $display("FAIL drop_one_toggle got=%0d want=1", bus.front_bank); end
        n_cmp++; if (bus.commit_busy !== 1'b0) begin n_bad++; $display("FAIL drop_no_queue got=%0d want=0", bus.commit_busy); end
        read(10'd7);
        n_cmp++; if (bus.rd_data !== 12'h070) begin n_bad++; $display("FAIL drop_rd7 got=%h want=070", bus.rd_data); end
        read(10'd8);
        n_cmp++; if (bus.rd_data !== 12'h080) begin n_bad++; $display("FAIL drop_rd8 got=%h want=080", bus.rd_data); end
        commit();
        frame();
        wait_idle(n);
        n_cmp++; if (n !== 961) begin n_bad++; $display("FAIL drop2_busy_len got=%0d want=961", n); end
        read(10'd8);
        n_cmp++; if (bus.rd_data !== 12'h080) begin n_bad++; $display("FAIL drop2_rd8 got=%h want=080", bus.rd_data); end
    endtask

    task automatic test_commit_frame_same();
        int n;
        bus.commit = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.commit = 1'b0;
        bus.frame_start = 1'b0;
        n_cmp++; if (bus.front_bank !== 1'b0) begin n_bad++; $display("FAIL same_front got=%0d want=0", bus.front_bank); end
        n_cmp++; if (bus.commit_busy !== 1'b1) begin n_bad++; $display("FAIL same_busy got=%0d want=1", bus.commit_busy); end
        frame();
        n_cmp++; if (bus.front_bank !== 1'b1) begin n_bad++; $display("FAIL same_next_front got=%0d want=1", bus.front_bank); end
        wait_idle(n);
        n_cmp++; if (n !== 961) begin n_bad++; $display("FAIL same_busy_len got=%0d want=961", n); end
    endtask

    task automatic test_blank_err_reset();
        int n;
        read(10'd5);
        n_cmp++; if (bus.rd_data !== 12'hABC) begin n_bad++; $display("FAIL blank_off_rd got=%h want=abc", bus.rd_data); end
        bus.blank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            read(i == 0 ? 10'd5 : (i == 1 ? 10'd0 : 10'd959));
            n_cmp++; if (bus.rd_data !== 12'h000) begin n_bad++; $display("FAIL blank_rd%0d got=%h want=000", i, bus.rd_data); end
        end
        bus.blank = 1'b0;
        read(10'd960);
        n_cmp++; if (bus.rd_data !== 12'h000) begin n_bad++; $display("FAIL oor_rd got=%h want=000", bus.rd_data); end
        write(10'd960, 12'h001);
        n_cmp++; if (bus.wr_err !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err got=%0d want=1", bus.wr_err); end
        write(10'd959, 12'h959);
        n_cmp++; if (bus.wr_err !== 1'b0) begin n_bad++; $display("FAIL edge_wr_err got=%0d want=0", bus.wr_err); end
        commit();
        frame();
        wait_idle(n);
        n_cmp++; if (bus.front_bank !== 1'b0) begin n_bad++; $display("FAIL rst_pre_front got=%0d want=0", bus.front_bank); end
        commit();
        frame();
        repeat (10) tick();
        n_cmp++; if (bus.front_bank !== 1'b1) begin n_bad++; $display("FAIL rst_mid_front got=%0d want=1", bus.front_bank); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (bus.front_bank !== 1'b0) begin n_bad++; $display("FAIL rst_copy_front got=%0d want=0", bus.front_bank); end
        n_cmp++; if (bus.commit_busy !== 1'b0) begin n_bad++; $display("FAIL rst_copy_busy got=%0d want=0", bus.commit_busy); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_copy_ready got=%0d want=1", bus.wr_ready); end
        n_cmp++; if (bus.frame_count !== 16'd0) begin n_bad++; $display("FAIL rst_copy_fcnt got=%0d want=0", bus.frame_count); end
        write(10'd3, 12'h333);
        n_cmp++; if (bus.wr_err !== 1'b0) begin n_bad++; $display("FAIL rst_idle_wr got=%0d want=0", bus.wr_err); end
    endtask

    task automatic test_frame_wrap();
        bus.frame_start = 1'b1;
        repeat (65535) tick();
        n_cmp++; if (bus.frame_count !== 16'hFFFF) begin n_bad++; $display("FAIL fcnt_max got=%0d want=65535", bus.frame_count); end
        tick();
        n_cmp++; if (bus.frame_count !== 16'd0) begin n_bad++; $display("FAIL fcnt_wrap got=%0d want=0", bus.frame_count); end
        repeat (3) tick();
        bus.frame_start = 1'b0;
        n_cmp++; if (bus.frame_count !== 16'd3) begin n_bad++; $display("FAIL fcnt_final got=%0d want=3", bus.frame_count); end
        n_cmp++; if (bus.front_bank !== 1'b0) begin n_bad++; $display("FAIL fcnt_front got=%0d want=0", bus.front_bank); end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.commit = 1'b0; bus.frame_start = 1'b0; bus.blank = 1'b0; bus.rd_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_no_swap();
        test_swap();
        test_drop();
        test_commit_frame_same();
        test_blank_err_reset();
        test_frame_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
